// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded lock sharing one data-memory port between core and loader
module dmem_arbiter #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 32,
    parameter int MaxBurst     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [1:0]              lock_i,
    input  logic [1:0]              we_i,
    input  logic [AddressWidth-1:0] addr0_i,
    input  logic [AddressWidth-1:0] addr1_i,
    input  logic [DataWidth-1:0]    wdata0_i,
    input  logic [DataWidth-1:0]    wdata1_i,
    input  logic [2:0]              funct3_0_i,
    input  logic [2:0]              funct3_1_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    core_stall_o,
    output logic                    mem_r_en_o,
    output logic                    mem_wr_en_o,
    output logic [AddressWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wr_data_o,
    output logic [2:0]              mem_funct3_o,
    input  logic [DataWidth-1:0]    mem_r_data_i
);
    localparam int CntW = $clog2(MaxBurst + 1);

    logic                 last_gnt_q, last_gnt_d;
    logic                 lock_vld_q, lock_vld_d;
    logic                 lock_own_q, lock_own_d;
    logic [CntW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [1:0]           rvalid_q, rvalid_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 below_max, forced, lock_hit, lock_set, any, sel, rd;

    // a lock only counts while its owner still requests and the burst budget remains
    assign below_max = burst_cnt_q < CntW'(MaxBurst);
    assign forced    = lock_vld_q && !below_max;
    assign lock_hit  = lock_vld_q && req_i[lock_own_q] && below_max;

    // lock holder first, then round-robin on contention, else the lone requester
    always_comb begin
        gnt_o = 2'b00;
        if (!rst_i) gnt_o = 2'b00;
        else if (lock_hit) gnt_o[lock_own_q] = 1'b1;
        else if (&req_i) gnt_o[!last_gnt_q] = 1'b1;
        else gnt_o = req_i;
    end

    assign any           = |gnt_o;
    assign sel           = gnt_o[1];
    assign rd            = any && !we_i[sel];
    assign core_stall_o  = req_i[0] & ~gnt_o[0];
    assign mem_r_en_o    = rd;
    assign mem_wr_en_o   = any && we_i[sel];
    assign mem_addr_o    = !any ? '0 : sel ? addr1_i : addr0_i;
    assign mem_wr_data_o = !any ? '0 : sel ? wdata1_i : wdata0_i;
    assign mem_funct3_o  = !any ? '0 : sel ? funct3_1_i : funct3_0_i;

    // next state: a new lock starts a fresh count, a continuing lock increments, anything else clears it
    always_comb begin
        lock_set    = any && lock_i[sel] && !forced;
        last_gnt_d  = any ? sel : last_gnt_q;
        lock_vld_d  = lock_set;
        lock_own_d  = lock_set ? sel : lock_own_q;
        burst_cnt_d = !lock_set ? '0 : (lock_vld_q && lock_own_q == sel) ? burst_cnt_q + CntW'(1) : CntW'(1);
        rvalid_d    = rd ? gnt_o : 2'b00;
        rdata_d     = rd ? mem_r_data_i : rdata_q;
    end

    // state registers; reset hands first priority to the core and drops any pending read return
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_gnt_q  <= 1'b1;
            lock_vld_q  <= 1'b0;
            lock_own_q  <= 1'b0;
            burst_cnt_q <= '0;
            rvalid_q    <= 2'b00;
            rdata_q     <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            lock_vld_q  <= lock_vld_d;
            lock_own_q  <= lock_own_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
endmodule
